// File: rtl/keypad_scan_buffer_if.sv
// Keypad read port seen by the peripheral controller: a pop strobe plus the packed status/key word.
interface keypad_scan_buffer_if;
  logic        pop;
  logic [31:0] key_word;

  modport master (output pop, input key_word);
  modport slave  (input pop, output key_word);
endinterface

// File: rtl/keypad_scan_buffer.sv
// 4x4 matrix keypad scanner with press/release debouncing and a key-event buffer.
// Define KEYPAD_FIFO_EN for a FIFO_DEPTH-entry event FIFO; the default build uses one holding register.
module keypad_scan_buffer #(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 10,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 rows,
  output logic [3:0]                 cols,
  keypad_scan_buffer_if.slave        bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  if (SCAN_DIV < 2 || DEBOUNCE_SAMPLES < 1 || FIFO_DEPTH < 2 || FIFO_DEPTH > 8 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("keypad_scan_buffer: illegal parameter value");
  end

  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       latch_q, latch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             tick;
  logic             push;
  logic [3:0]       push_code;

  logic             buf_valid;
  logic             buf_ovf;
  logic [3:0]       buf_count;
  logic [3:0]       buf_code;

  // Lowest-numbered low row wins when several keys in a column are down.
  function automatic logic [1:0] row_index(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
  assign cnt_inc   = cnt_q + 1'b1;
  assign push_code = {row_index(sync2_q), col_q};
  assign cols      = ~(4'b0001 << col_q);

  always_comb begin
    sync1_d = rows;
    sync2_d = sync1_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    state_d = state_q;
    col_d   = col_q;
    latch_d = latch_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (sync2_q == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            latch_d = sync2_q;
            cnt_d   = CNT_W'(1);
            if (DEBOUNCE_SAMPLES == 1) begin
              push    = 1'b1;
              state_d = ST_HELD;
            end else begin
              state_d = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if (sync2_q == latch_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SAMPLES)) begin
              push    = 1'b1;
              state_d = ST_HELD;
            end
          end else if (sync2_q == 4'hF) begin
            state_d = ST_SCAN;
          end else begin
            latch_d = sync2_q;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (sync2_q == 4'hF) begin
            cnt_d = CNT_W'(1);
            if (DEBOUNCE_SAMPLES == 1) begin
              state_d = ST_SCAN;
              col_d   = col_q + 2'd1;
            end else begin
              state_d = ST_REL_DB;
            end
          end
        end
        ST_REL_DB: begin
          if (sync2_q == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SAMPLES)) begin
              state_d = ST_SCAN;
              col_d   = col_q + 2'd1;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      div_q   <= '0;
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      latch_q <= 4'hF;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      state_q <= state_d;
      col_q   <= col_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KEYPAD_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [3:0]       fifo_q [FIFO_DEPTH];
  logic [3:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_pop;

  // Pop is applied before push, so a full FIFO still accepts a push in a pop cycle.
  always_comb begin
    fifo_d  = fifo_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    do_pop  = bus.pop && (count_q != 4'd0);
    if (do_pop) rd_d = rd_q + 1'b1;
    if (push && (do_pop || count_q != 4'(FIFO_DEPTH))) begin
      fifo_d[wr_q] = push_code;
      wr_d         = wr_q + 1'b1;
    end else if (push) begin
      ovf_d = 1'b1;
    end
    if (do_pop && !push) begin
      count_d = count_q - 4'd1;
      if (count_q == 4'd1) ovf_d = 1'b0;
    end else if (push && !do_pop && count_q != 4'(FIFO_DEPTH)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign buf_valid = (count_q != 4'd0);
  assign buf_ovf   = ovf_q;
  assign buf_count = count_q;
  assign buf_code  = fifo_q[rd_q];
`else
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;

  // A push into an occupied register overwrites it; only a push without a pop flags overflow.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (push) begin
      code_d  = push_code;
      valid_d = 1'b1;
      ovf_d   = valid_q && !bus.pop;
    end else if (bus.pop && valid_q) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign buf_valid = valid_q;
  assign buf_ovf   = ovf_q;
  assign buf_count = {3'd0, valid_q};
  assign buf_code  = code_q;
`endif

  assign bus.key_word = {buf_valid, buf_ovf, 22'd0, buf_count, buf_valid ? buf_code : 4'd0};

endmodule

// File: tb/tb_keypad_scan_buffer.sv
// Directed bench for keypad_scan_buffer: a behavioural keypad drives rows from cols; checks both buffer builds.
`timescale 1ns/1ps
module tb_keypad_scan_buffer;

  localparam int SCAN_DIV         = 4;
  localparam int DEBOUNCE_SAMPLES = 3;
  localparam int FIFO_DEPTH       = 4;

  typedef struct {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [31:0] push_word;
    logic [31:0] pop_word;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_down = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [1:0] key_col = 2'd0;
  int         tests_run = 0;
  int         tests_failed = 0;
  vec_t       vecs [5];
  bit         col_ok;

  keypad_scan_buffer_if bus ();

  keypad_scan_buffer #(
    .SCAN_DIV         (SCAN_DIV),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
    .FIFO_DEPTH       (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rows  (rows),
    .cols  (cols),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  assign rows = (key_down && cols[key_col] == 1'b0) ? ~(4'b0001 << key_row) : 4'hF;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic press_key(input logic [1:0] row, input logic [1:0] col);
    key_row  = row;
    key_col  = col;
    key_down = 1'b1;
    wait_cycles(36);
    key_down = 1'b0;
    wait_cycles(24);
  endtask

  task automatic pop_once();
    bus.pop = 1'b1;
    wait_cycles(1);
    bus.pop = 1'b0;
  endtask

  task automatic wait_for_column(input logic [1:0] col, output bit ok);
    logic [3:0] target;
    logic [3:0] prev;
    target = ~(4'b0001 << col);
    prev   = cols;
    ok     = 1'b0;
    for (int i = 0; i < 24 && !ok; i++) begin
      wait_cycles(1);
      if (cols == target && prev != target) ok = 1'b1;
      prev = cols;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.pop = 1'b0;

`ifdef KEYPAD_FIFO_EN
    vecs[0] = '{2'd1, 2'd2, 32'h8000_0016, 32'hC000_003C};
    vecs[1] = '{2'd3, 2'd0, 32'h8000_0026, 32'hC000_0023};
    vecs[2] = '{2'd0, 2'd3, 32'h8000_0036, 32'hC000_0019};
    vecs[3] = '{2'd2, 2'd1, 32'h8000_0046, 32'h0000_0000};
    vecs[4] = '{2'd3, 2'd3, 32'hC000_0046, 32'h0000_0000};
`else
    vecs[0] = '{2'd1, 2'd2, 32'h8000_0016, 32'h0000_0000};
    vecs[1] = '{2'd3, 2'd0, 32'hC000_001C, 32'h0000_0000};
    vecs[2] = '{2'd0, 2'd3, 32'hC000_0013, 32'h0000_0000};
    vecs[3] = '{2'd2, 2'd1, 32'hC000_0019, 32'h0000_0000};
    vecs[4] = '{2'd3, 2'd3, 32'hC000_001F, 32'h0000_0000};
`endif

    // Reset values, then idle column rotation once every SCAN_DIV clocks.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_cols", {28'd0, cols}, 32'h0000_000E);
    check_output("reset_word", bus.key_word, 32'h0000_0000);
    reset = 1'b1;
    wait_cycles(3);
    check_output("cols_pre_tick", {28'd0, cols}, 32'h0000_000E);
    wait_cycles(1);
    check_output("cols_tick1", {28'd0, cols}, 32'h0000_000D);
    wait_cycles(4);
    check_output("cols_tick2", {28'd0, cols}, 32'h0000_000B);
    wait_cycles(4);
    check_output("cols_tick3", {28'd0, cols}, 32'h0000_0007);
    wait_cycles(4);
    check_output("cols_tick4", {28'd0, cols}, 32'h0000_000E);

    // Row 1 / column 2: detected on the 3rd tick, accepted on the 5th, released over 3 ticks.
    apply_reset();
    key_row  = 2'd1;
    key_col  = 2'd2;
    key_down = 1'b1;
    wait_cycles(19);
    check_output("press_before_accept", bus.key_word, 32'h0000_0000);
    wait_cycles(1);
    check_output("press_accept_word", bus.key_word, 32'h8000_0016);
    check_output("press_held_cols", {28'd0, cols}, 32'h0000_000B);
    key_down = 1'b0;
    wait_cycles(11);
    check_output("release_frozen_cols", {28'd0, cols}, 32'h0000_000B);
    wait_cycles(1);
    check_output("release_resume_cols", {28'd0, cols}, 32'h0000_0007);
    check_output("release_no_event", bus.key_word, 32'h8000_0016);
    pop_once();
    check_output("pop_to_empty", bus.key_word, 32'h0000_0000);

    // Bouncing contact never survives two consecutive samples.
    apply_reset();
    key_row = 2'd2;
    key_col = 2'd0;
    for (int i = 0; i < 10; i++) begin
      key_down = (i % 2 == 0);
      wait_cycles(4);
      check_output($sformatf("bounce_tick%0d", i), bus.key_word, 32'h0000_0000);
    end
    key_down = 1'b0;
    check_output("bounce_cols", {28'd0, cols}, 32'h0000_000E);

    // Five presses without a pop, then five pops (the last one on an empty buffer).
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      press_key(vecs[i].row, vecs[i].col);
      check_output($sformatf("push%0d", i), bus.key_word, vecs[i].push_word);
    end
    for (int i = 0; i < 5; i++) begin
      pop_once();
      check_output($sformatf("pop%0d", i), bus.key_word, vecs[i].pop_word);
    end

    // Push and pop landing on the same clock edge.
    apply_reset();
    for (int i = 0; i < 4; i++) press_key(vecs[i].row, vecs[i].col);
    wait_for_column(2'd0, col_ok);
    check_output("col0_wait", {31'd0, col_ok}, 32'd1);
    key_row  = 2'd1;
    key_col  = 2'd0;
    key_down = 1'b1;
    wait_cycles(11);
`ifdef KEYPAD_FIFO_EN
    check_output("pushpop_before", bus.key_word, 32'h8000_0046);
`else
    check_output("pushpop_before", bus.key_word, 32'hC000_0019);
`endif
    bus.pop = 1'b1;
    wait_cycles(1);
    bus.pop = 1'b0;
`ifdef KEYPAD_FIFO_EN
    check_output("pushpop_after", bus.key_word, 32'h8000_004C);
`else
    check_output("pushpop_after", bus.key_word, 32'h8000_0014);
`endif
    key_down = 1'b0;
    wait_cycles(24);

    // Reset two samples into a press; the held key must then debounce from scratch.
    apply_reset();
    key_row  = 2'd0;
    key_col  = 2'd0;
    key_down = 1'b1;
    wait_cycles(8);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("middb_reset_cols", {28'd0, cols}, 32'h0000_000E);
    check_output("middb_reset_word", bus.key_word, 32'h0000_0000);
    reset = 1'b1;
    wait_cycles(11);
    check_output("middb_no_early_event", bus.key_word, 32'h0000_0000);
    wait_cycles(1);
    check_output("middb_fresh_accept", bus.key_word, 32'h8000_0010);
    key_down = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
